// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture_if
//  Purpose  : Register-side bundle for pwm_capture. The peripheral register
//             block drives the capture enable and reads back the measurement
//             and status bits.
//  Signals  : enable        - capture enable (register side -> capture)
//             period_count  - last complete period, in clocks
//             high_count    - active clocks in the last complete period
//             meas_valid    - period_count/high_count hold a valid result
//             meas_stb      - one-cycle pulse when new values are loaded
//             stuck         - no active edge for TIMEOUT_COUNT clocks
//             stuck_level   - synchronized input level when stuck was set
//             overflow      - sticky, a period counter saturated
//  Modports : master - register side, slave - pwm_capture
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_capture_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 enable;
    logic [CNT_WIDTH-1:0] period_count;
    logic [CNT_WIDTH-1:0] high_count;
    logic                 meas_valid;
    logic                 meas_stb;
    logic                 stuck;
    logic                 stuck_level;
    logic                 overflow;

    modport master (
        output enable,
        input  period_count, high_count, meas_valid, meas_stb,
               stuck, stuck_level, overflow
    );

    modport slave (
        input  enable,
        output period_count, high_count, meas_valid, meas_stb,
               stuck, stuck_level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures period and active time of an asynchronous PWM input in
//             system clocks, and flags an input that stops toggling.
//  Ports    : clk     - system clock
//             resetn  - asynchronous active-low reset
//             pwm_in  - asynchronous PWM input
//             bus     - pwm_capture_if.slave (enable in; results/status out)
//  Params   : CNT_WIDTH     - width of counters and results
//             TIMEOUT_COUNT - clocks without an active edge before stuck
//                             (2 <= TIMEOUT_COUNT < 2^CNT_WIDTH - 1)
//             POLARITY      - 1: measure high time, rising edge is active
//                             0: measure low time, falling edge is active
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned TIMEOUT_COUNT = 2000000,
    parameter logic        POLARITY      = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      resetn,
    input  wire logic      pwm_in,
    pwm_capture_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] c_ALL_ONES     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_ONE          = CNT_WIDTH'(1);
    // Idle counter restarts at 0 after the edge cycle, so this value is
    // reached on the TIMEOUT_COUNT-th clock after that edge.
    localparam logic [CNT_WIDTH-1:0] c_TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_STUCK   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_enter_stuck;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_dly;
    logic                 w_act;
    logic                 w_act_dly;
    logic                 w_edge;
    logic                 w_timeout;

    logic [CNT_WIDTH-1:0] r_run_period;
    logic [CNT_WIDTH-1:0] r_run_high;
    logic [CNT_WIDTH-1:0] r_idle;
    logic [CNT_WIDTH-1:0] r_period_count;
    logic [CNT_WIDTH-1:0] r_high_count;
    logic                 r_meas_valid;
    logic                 r_meas_stb;
    logic                 r_stuck_level;
    logic                 r_overflow;

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchronizer plus one delay stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_act     = r_sync2 ~^ POLARITY;
    assign w_act_dly = r_dly ~^ POLARITY;
    assign w_edge    = w_act & ~w_act_dly;
    assign w_timeout = (r_idle == c_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_enter_stuck = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARM;
                end
                S_ARM: begin
                    // First edge only aligns the counters; nothing to report yet.
                    if (w_edge) begin
                        w_state_nxt = S_MEASURE;
                    end else if (w_timeout) begin
                        w_state_nxt   = S_STUCK;
                        w_enter_stuck = 1'b1;
                    end
                end
                S_MEASURE: begin
                    // An edge on the timeout cycle still counts as activity.
                    if (w_edge) begin
                        w_load = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt   = S_STUCK;
                        w_enter_stuck = 1'b1;
                    end
                end
                S_STUCK: begin
                    if (w_edge) begin
                        w_state_nxt = S_MEASURE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run_period   <= '0;
            r_run_high     <= '0;
            r_idle         <= '0;
            r_period_count <= '0;
            r_high_count   <= '0;
            r_meas_valid   <= 1'b0;
            r_meas_stb     <= 1'b0;
            r_stuck_level  <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (!bus.enable || (r_state == S_IDLE)) begin
            r_run_period   <= '0;
            r_run_high     <= '0;
            r_idle         <= '0;
            r_period_count <= '0;
            r_high_count   <= '0;
            r_meas_valid   <= 1'b0;
            r_meas_stb     <= 1'b0;
            r_stuck_level  <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            // The edge cycle is itself the first clock of the new period,
            // and it is an active clock, hence the restart at 1.
            if (w_edge) begin
                r_run_period <= c_ONE;
                r_run_high   <= c_ONE;
                r_idle       <= '0;
            end else if (r_state != S_STUCK) begin
                // Frozen while stuck so a long dead input cannot overflow.
                if (r_run_period != c_ALL_ONES) begin
                    r_run_period <= r_run_period + c_ONE;
                end
                if (w_act && (r_run_high != c_ALL_ONES)) begin
                    r_run_high <= r_run_high + c_ONE;
                end
                if (!w_timeout) begin
                    r_idle <= r_idle + c_ONE;
                end
            end

            if (r_run_period == c_ALL_ONES) begin
                r_overflow <= 1'b1;
            end

            r_meas_stb <= w_load;
            if (w_load) begin
                r_period_count <= r_run_period;
                r_high_count   <= r_run_high;
                r_meas_valid   <= 1'b1;
            end

            if (w_enter_stuck) begin
                r_meas_valid  <= 1'b0;
                r_stuck_level <= r_sync2;
            end
        end
    end

    assign bus.period_count = r_period_count;
    assign bus.high_count   = r_high_count;
    assign bus.meas_valid   = r_meas_valid;
    assign bus.meas_stb     = r_meas_stb;
    assign bus.stuck        = (r_state == S_STUCK);
    assign bus.stuck_level  = r_stuck_level;
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire
